// File: rtl/frame_serializer_if.sv
// frame_serializer_if: word handshake plus serial line bundle for frame_serializer
//   data_in/data_valid : producer -> serializer word and its valid flag
//   data_ready         : serializer -> producer, a word can be taken this cycle
//   data_out           : serial line, idle high
//   busy               : frame in progress or word buffered
interface frame_serializer_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] data_in;
  logic                  data_valid;
  logic                  data_ready;
  logic                  data_out;
  logic                  busy;
  modport master (output data_in, data_valid, input data_ready, data_out, busy);
  modport slave  (input data_in, data_valid, output data_ready, data_out, busy);
endinterface

// File: rtl/frame_serializer.sv
// frame_serializer: framed serial transmitter (start, data, optional parity, stop) with a one-word holding buffer
//   clock : system clock, all logic on posedge
//   reset : synchronous active-high reset
//   bus   : frame_serializer_if.slave (data_in, data_valid, data_ready, data_out, busy)
//   Optional parity bit enabled by defining FRAME_SERIALIZER_PARITY_EN.
module frame_serializer #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 1,
  parameter int STOP_BITS    = 1,
  parameter int MSB_FIRST    = 0
) (
  input logic               clock,
  input logic               reset,
  frame_serializer_if.slave bus
);
  localparam int DIV_W = CLKS_PER_BIT > 1 ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W = $clog2(DATA_WIDTH + STOP_BITS + 1);
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef FRAME_SERIALIZER_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;
  localparam state_t POST_DATA =
`ifdef FRAME_SERIALIZER_PARITY_EN
    PARITY;
`else
    STOP;
`endif
  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d, buf_q, buf_d, load_word;
  logic                  full_q, full_d, load;
  logic [DIV_W-1:0]      div_q, div_d;
  logic [BIT_W-1:0]      bit_q, bit_d;
  logic                  out_q, out_d, busy_q, busy_d, ready_q, ready_d;
  logic                  wrap, tick, accept, last_data, last_stop, line_d;
  assign wrap      = div_q == DIV_W'(CLKS_PER_BIT - 1);
  assign tick      = state_q != IDLE && wrap;
  assign accept    = bus.data_valid && ready_q;
  assign last_data = bit_q == BIT_W'(DATA_WIDTH - 1);
  assign last_stop = bit_q == BIT_W'(STOP_BITS - 1);
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    buf_d     = buf_q;
    full_d    = full_q;
    bit_d     = bit_q;
    div_d     = (state_q == IDLE || wrap) ? '0 : div_q + 1'b1;
    load      = state_q == IDLE && accept;
    load_word = bus.data_in;
    if (accept && state_q != IDLE) begin
      buf_d  = bus.data_in;
      full_d = 1'b1;
    end
    if (tick)
      case (state_q)
        START: begin
          state_d = DATA;
          bit_d   = '0;
        end
        DATA: begin
          shift_d = MSB_FIRST != 0 ? shift_q << 1 : shift_q >> 1;
          bit_d   = last_data ? '0 : bit_q + 1'b1;
          state_d = last_data ? POST_DATA : DATA;
        end
`ifdef FRAME_SERIALIZER_PARITY_EN
        PARITY: state_d = STOP;
`endif
        STOP: begin
          bit_d = last_stop ? '0 : bit_q + 1'b1;
          if (last_stop) begin
            // a word taken on the final stop edge starts straight away instead of parking in the buffer
            state_d   = IDLE;
            load      = full_q || accept;
            load_word = full_q ? buf_q : bus.data_in;
            full_d    = 1'b0;
          end
        end
        default: ;
      endcase
    if (load) begin
      state_d = START;
      shift_d = load_word;
      bit_d   = '0;
      div_d   = '0;
    end
  end
`ifdef FRAME_SERIALIZER_PARITY_EN
  logic par_q, par_d;
  assign par_d = load ? ^load_word : par_q;
  always_ff @(posedge clock)
    par_q <= reset ? 1'b0 : par_d;
  assign line_d = state_d == PARITY ? par_d : 1'b1;
`else
  assign line_d = 1'b1;
`endif
  // outputs are registered, so they are derived from next-state values
  assign out_d   = state_d == START ? 1'b0 :
                   state_d == DATA  ? (MSB_FIRST != 0 ? shift_d[DATA_WIDTH-1] : shift_d[0]) : line_d;
  assign busy_d  = state_d != IDLE || full_d;
  assign ready_d = !full_d;
  always_ff @(posedge clock)
    if (reset) begin
      state_q <= IDLE;
      shift_q <= '0;
      buf_q   <= '0;
      full_q  <= 1'b0;
      div_q   <= '0;
      bit_q   <= '0;
      out_q   <= 1'b1;
      busy_q  <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      buf_q   <= buf_d;
      full_q  <= full_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      out_q   <= out_d;
      busy_q  <= busy_d;
      ready_q <= ready_d;
    end
  assign bus.data_out   = out_q;
  assign bus.busy       = busy_q;
  assign bus.data_ready = ready_q;
endmodule
